// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: drives A/B of the 5-state handshake FSM through one full pass, confirming steps via o_a/o_b and timing out stalls; optional abort input under FSM_SEQ_ABORT_EN
module fsm_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic [3:0] hold_cycles,
  input  logic       fb_a,
  input  logic       fb_b,
`ifdef FSM_SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_step,
  output logic [2:0] step
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_S1 = 3'd1,
    DWELL1  = 3'd2,
    GO_S2   = 3'd3,
    DWELL2  = 3'd4,
    GO_S3   = 3'd5,
    EXIT    = 3'd6,
    SETTLE  = 3'd7
  } state_t;
  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [3:0]      hold_q, hold_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [3:0]      dw_q, dw_d;
  logic            a_q, a_d, b_q, b_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [2:0]      err_step_q, err_step_d;
  logic [3:0]      hold_eff;
  logic            dwell_last, waiting, cond;
  logic            abort_req;
`ifdef FSM_SEQ_ABORT_EN
  assign abort_req = abort & busy_q;
`else
  assign abort_req = 1'b0;
`endif
  assign hold_eff   = (hold_q == 4'd0) ? 4'd1 : hold_q;
  assign dwell_last = (dw_q == hold_eff - 4'd1);
  // next-state, counters and registered output values derived from the next state
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    dw_d       = dw_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_step_d = err_step_q;
    waiting    = 1'b0;
    cond       = 1'b0;
    case (state_q)
      IDLE: if (start && !done_q && !err_q) begin
        state_d    = WAIT_S1;
        mode_d     = mode;
        hold_d     = hold_cycles;
        err_step_d = 3'd0;
      end
      WAIT_S1: begin
        waiting = 1'b1;
        cond    = fb_a & ~fb_b;
        if (cond) state_d = DWELL1;
      end
      DWELL1: state_d = dwell_last ? GO_S2 : DWELL1;
      GO_S2: begin
        waiting = 1'b1;
        cond    = fb_b;
        if (cond) state_d = DWELL2;
      end
      DWELL2: state_d = dwell_last ? GO_S3 : DWELL2;
      GO_S3: begin
        waiting = 1'b1;
        cond    = ~fb_a & ~fb_b;
        if (cond) state_d = EXIT;
      end
      EXIT: begin
        waiting = ~mode_q;
        cond    = fb_a;
        if (mode_q || cond) state_d = SETTLE;
      end
      SETTLE: if (dw_q == 4'd1) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (waiting && !cond) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d    = IDLE;
        err_d      = 1'b1;
        err_step_d = state_q;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    if (abort_req) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      done_d     = 1'b0;
      err_step_d = 3'd0;
    end
    dw_d = (state_d != state_q) ? 4'd0 : (state_q inside {DWELL1, DWELL2, SETTLE}) ? dw_q + 4'd1 : dw_q;
    if (state_d != state_q) tmo_d = '0;
    a_d    = (state_d inside {GO_S2, GO_S3}) || (state_d == EXIT && mode_d);
    b_d    = (state_d inside {GO_S2, GO_S3}) || (state_d == EXIT && !mode_d);
    busy_d = (state_d != IDLE);
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      hold_q     <= '0;
      tmo_q      <= '0;
      dw_q       <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_step_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      hold_q     <= hold_d;
      tmo_q      <= tmo_d;
      dw_q       <= dw_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_step_q <= err_step_d;
    end
  end
  assign a_out    = a_q;
  assign b_out    = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_step = err_step_q;
  assign step     = state_q;
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb_fsm_seq_ctrl: directed bench for fsm_seq_ctrl with a negedge-clocked handshake FSM model on the feedback path
module tb_fsm_seq_ctrl;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [3:0] hold_cycles = 4'd0;
  logic       fb_a, fb_b, a_out, b_out, busy, done, err;
  logic [2:0] err_step, step;
  logic [2:0] fsm_q;
  logic       fsm_rst = 1'b0, tie_b0 = 1'b0, m_rst;
  int         total = 0, bad = 0;
  int         done_cnt, done_at, err_seen;
  logic       hit;
  logic [2:0] st0 [12] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd0};
  logic [1:0] ab0 [12] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  logic [2:0] st1 [9]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd0};
  logic [1:0] ab1 [9]  = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0};

  fsm_seq_ctrl #(.TIMEOUT(16), .TW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .hold_cycles(hold_cycles),
    .fb_a(fb_a), .fb_b(fb_b),
`ifdef FSM_SEQ_ABORT_EN
    .abort(abort),
`endif
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .err(err),
    .err_step(err_step), .step(step)
  );

  always #5 clk = ~clk;

  assign m_rst = rst | fsm_rst;
  assign fb_a  = (fsm_q == 3'd1) || (fsm_q == 3'd2);
  assign fb_b  = (fsm_q == 3'd2) && !tie_b0;

  // handshake FSM model: IDLE->S1 always, S1/S2 advance on A&B, S3 exits on 01 (IDLE) or 10 (S4)
  always @(negedge clk or posedge m_rst) begin
    if (m_rst) fsm_q <= 3'd0;
    else case (fsm_q)
      3'd0: fsm_q <= 3'd1;
      3'd1: fsm_q <= (a_out && b_out) ? 3'd2 : 3'd1;
      3'd2: fsm_q <= (a_out && b_out) ? 3'd3 : 3'd2;
      3'd3: fsm_q <= (!a_out && b_out) ? 3'd0 : (a_out && !b_out) ? 3'd4 : 3'd3;
      default: fsm_q <= fsm_q;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fsm_reset();
    fsm_rst = 1'b1;
    tick();
    fsm_rst = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_step", step, 0);
    chk("rst_ab", {a_out, b_out}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_step", err_step, 0);
    rst = 1'b0;
    repeat (3) tick();
    // mode 0, hold 2: full pass returning FSM to S1
    mode = 1'b0; hold_cycles = 4'd2; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      start = 1'b0;
      chk($sformatf("m0_step%0d", i), step, st0[i]);
      chk($sformatf("m0_ab%0d", i), {a_out, b_out}, ab0[i]);
      chk($sformatf("m0_busy%0d", i), busy, i < 11);
      chk($sformatf("m0_done%0d", i), done, i == 11);
      chk($sformatf("m0_err%0d", i), err, 0);
    end
    chk("m0_fsm_s1", {fb_a, fb_b}, 2'b10);
    tick();
    chk("m0_done_once", done, 0);
    // mode 1, hold 0: one-cycle dwells and a single 10 exit cycle into S4
    mode = 1'b1; hold_cycles = 4'd0; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      start = 1'b0;
      chk($sformatf("m1_step%0d", i), step, st1[i]);
      chk($sformatf("m1_ab%0d", i), {a_out, b_out}, ab1[i]);
      chk($sformatf("m1_busy%0d", i), busy, i < 8);
      chk($sformatf("m1_done%0d", i), done, i == 8);
    end
    chk("m1_fsm_s4", {fb_a, fb_b}, 2'b00);
    // timeout in GO_S2 with fb_b stuck low
    fsm_reset();
    tie_b0 = 1'b1;
    mode = 1'b0; hold_cycles = 4'd1; start = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick();
      start = 1'b0;
      chk($sformatf("to_step%0d", i), step, (i == 0) ? 1 : (i == 1) ? 2 : (i == 18) ? 0 : 3);
      chk($sformatf("to_err%0d", i), err, i == 18);
      chk($sformatf("to_busy%0d", i), busy, i < 18);
      chk($sformatf("to_done%0d", i), done, 0);
      if (i >= 2) chk($sformatf("to_ab%0d", i), {a_out, b_out}, (i == 18) ? 0 : 3);
    end
    chk("to_err_step", err_step, 3);
    tick();
    chk("to_err_pulse", err, 0);
    chk("to_err_step_hold", err_step, 3);
    tie_b0 = 1'b0;
    // extra starts during DWELL1 and on the done cycle are dropped
    fsm_reset();
    mode = 1'b0; hold_cycles = 4'd3; start = 1'b1;
    done_cnt = 0; done_at = -1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      start = (i == 1) || done;
    end
    start = 1'b0;
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_done_at", done_at, 13);
    chk("ign_busy", busy, 0);
    chk("ign_step", step, 0);
    // asynchronous reset in the middle of GO_S3, then a clean pass
    mode = 1'b0; hold_cycles = 4'd1; start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      start = 1'b0;
      hit = (step == 3'd5);
    end
    chk("ar_reach_go_s3", hit, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_step", step, 0);
    chk("ar_ab", {a_out, b_out}, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    start = 1'b1;
    hit = 1'b0; err_seen = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      start = 1'b0;
      hit = done;
      if (err) err_seen++;
    end
    chk("ar_pass_done", hit, 1);
    chk("ar_pass_err", err_seen, 0);
`ifdef FSM_SEQ_ABORT_EN
    // abort in DWELL2, then abort while idle
    tick();
    fsm_reset();
    mode = 1'b0; hold_cycles = 4'd2; start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      start = 1'b0;
      hit = (step == 3'd4);
    end
    chk("ab_reach_dwell2", hit, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_step", step, 0);
    chk("ab_err", err, 1);
    chk("ab_err_step", err_step, 0);
    chk("ab_ab", {a_out, b_out}, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle_err", err, 0);
    chk("ab_idle_step", step, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
- Sequencer that drives the A/B inputs of the team's 5-state handshake FSM (IDLE→S1→S2→S3→{IDLE|S4}) through a complete programmed pass.
- Confirms each transition using the FSM's o_a/o_b feedback and flags any step that stalls beyond a timeout.
- Sits between a host/test controller and one FSM instance; all outputs are registered.

Parameters:
- TIMEOUT, 16, max cycles spent in any WAIT state before error (≥2).
- TW, 5, width of timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass; ignored while busy=1.
- mode  in  1  exit path, sampled at start: 0 = return FSM to IDLE (then S1); 1 = drive FSM into S4.
- hold_cycles  in  4  dwell cycles in S1 and S2, sampled at start; 0 treated as 1.
- fb_a  in  1  FSM o_a feedback (high in S1/S2).
- fb_b  in  1  FSM o_b feedback (high in S2).
- a_out  out  1  drives FSM input A.
- b_out  out  1  drives FSM input B.
- busy  out  1  high from the cycle after start until done/err.
- done  out  1  one-cycle pulse, pass completed.
- err  out  1  one-cycle pulse, timeout.
- err_step  out  3  step code of the timed-out state; held until next start.
- step  out  3  current state code.

Behaviour:
- Reset (asynchronous, any time, including mid-pass): state=IDLE, a_out=b_out=0, busy=done=err=0, err_step=0, counters=0. Next pass requires a new start.
- Step codes: IDLE=0, WAIT_S1=1, DWELL1=2, GO_S2=3, DWELL2=4, GO_S3=5, EXIT=6, SETTLE=7.
- IDLE:
  - a/b=00.
  - On start: latch mode and hold_cycles, go to WAIT_S1, busy=1 on the next cycle.
- WAIT_S1:
  - a/b=00; wait for fb_a=1 & fb_b=0.
  - Then go to DWELL1.
- DWELL1:
  - a/b=00 for max(hold_cycles,1) cycles.
  - Then go to GO_S2.
- GO_S2:
  - a/b=11; wait for fb_b=1.
  - Then go to DWELL2.
- DWELL2:
  - a/b=00 for max(hold_cycles,1) cycles; FSM must stay in S2.
  - Then go to GO_S3.
- GO_S3:
  - a/b=11; FSM leaves S2, then holds in S3 because A&B keeps S3.
  - Wait for fb_a=0 & fb_b=0.
  - Then go to EXIT.
- EXIT:
  - mode=0: a/b=01; wait for fb_a=1 (FSM S3→IDLE→S1).
  - mode=1: a/b=10 for exactly 1 cycle, no wait.
  - Then go to SETTLE.
- SETTLE:
  - a/b=00 for 2 cycles.
  - Then done=1 for one cycle, busy=0, return to IDLE.
- Timeout:
  - Counter clears on entry to each WAIT state (WAIT_S1, GO_S2, GO_S3, EXIT mode 0) and increments each cycle the condition is false.
  - If the condition is met within TIMEOUT cycles after entry, advance.
  - If the counter reaches TIMEOUT: err=1 for one cycle, err_step=current code, a/b=00, busy=0, return to IDLE. done is not asserted.
  - A condition true on the same cycle the counter reaches TIMEOUT counts as a success.
- Feedback is used combinationally in next-state logic; the transition takes effect on the following edge.
- A start pulse while busy=1 is dropped, with no queuing.
- A start pulse on the same cycle as the done/err pulse is ignored.
- a_out/b_out change only on clock edges, so there are no glitches toward the FSM.

Optional Feature:
- Macro: FSM_SEQ_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 while busy: next cycle a/b=00, err=1, err_step=7'h? → err_step=3'd0 (abort marker), return to IDLE.
  - abort takes priority over timeout and done on the same cycle.
  - abort is ignored in IDLE.
- When undefined: no abort port; behaviour exactly as above.

Test Plan:
- mode=0, hold_cycles=2, bench FSM model connected, start at cycle 5: a/b sequence 00,00..,11,00,00,11,01,00,00. done pulses once, FSM ends in S1, err never asserted.
- mode=1, hold_cycles=0: dwells last 1 cycle; EXIT drives a/b=10 for exactly one cycle; FSM ends in S4 (fb 00); done=1, busy falls the same cycle.
- fb_b tied 0, TIMEOUT=16: in GO_S2 after 16 cycles, err=1 for one cycle, err_step=3, a/b=00, busy=0, done=0.
- Second start pulse during DWELL1 plus a start on the done cycle: both ignored, exactly one done pulse, no second pass.
- rst asserted mid-GO_S3 for 1 cycle: all outputs 0 immediately (asynchronous), step=0; a new start then completes a normal pass.
- With FSM_SEQ_ABORT_EN: abort in DWELL2 → next cycle a/b=00, err=1, err_step=0, IDLE; abort in IDLE → no effect.
